// File: rtl/cnn_weight_reader.sv
// Purpose: streams a run of 5x5 weight windows from CNN memory to the conv engine.
// Latency: first mem_re one cycle after start; first out_valid two cycles after that.
// Backpressure: reads are issued only while a 2-entry FIFO slot is guaranteed; out_ready stalls issue.
// Optional build macro: CNN_READER_CHECKSUM_EN adds a running per-run word checksum output.

// Small synchronous FIFO; caller guarantees no push when full and no pop when empty.
module cnn_weight_reader_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointer and occupancy tracking; push and pop in the same cycle leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; contents are only observed while count is nonzero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
endmodule

module cnn_weight_reader #(
  parameter int ADDR_W         = 16,
  parameter int WORD_W         = 16,
  parameter int WORDS_PER_READ = 25,
  parameter int STRIDE         = 25,
  parameter int CNT_W          = 12
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [ADDR_W-1:0]                base_addr,
  input  logic [CNT_W-1:0]                 num_reads,
  output logic                             busy,
  output logic                             done,
  output logic                             start_err,
  output logic                             mem_re,
  output logic [ADDR_W-1:0]                mem_addr,
  input  logic [WORDS_PER_READ*WORD_W-1:0] mem_rdata,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WORDS_PER_READ*WORD_W-1:0] out_data,
  output logic                             out_last
`ifdef CNN_READER_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0]                checksum
`endif
);
  localparam int DW = WORDS_PER_READ * WORD_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  issued_q;
  logic [CNT_W-1:0]  acc_q;
  logic [ADDR_W-1:0] addr_q;
  logic              inflight_q;
  logic [1:0]        fifo_cnt;
  logic [DW-1:0]     fifo_head;
  logic              pop;
  logic              start_acc;
  logic [2:0]        credit_used;
  logic              credit_ok;

  assign start_acc = start && (state_q == IDLE);
  assign out_valid = (fifo_cnt != 2'd0);
  assign pop       = out_valid && out_ready;

  // A slot freed by this cycle's pop is reusable by a read issued now, since the
  // data lands two edges later; this keeps one window per cycle with a 2-deep buffer.
  assign credit_used = 3'(fifo_cnt) + 3'(inflight_q) - 3'(pop);
  assign credit_ok   = (credit_used < 3'd2);

  // Next-state and read-issue decode.
  always_comb begin
    state_d = state_q;
    mem_re  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A zero-length run passes through DRAIN (trivially satisfied) so done
        // still lands two cycles after start.
        if (start) state_d = (num_reads == '0) ? DRAIN : FETCH;
      end
      FETCH: begin
        if ((issued_q < num_q) && credit_ok) begin
          mem_re = 1'b1;
          if (issued_q == num_q - 1'b1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((acc_q == num_q) || (pop && (acc_q == num_q - 1'b1))) state_d = FINISH;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Run parameters, address generation, issue/accept counters and read pipeline tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q      <= '0;
      issued_q   <= '0;
      acc_q      <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= mem_re;
      if (start_acc) begin
        num_q    <= num_reads;
        issued_q <= '0;
        acc_q    <= '0;
        addr_q   <= base_addr;
      end else begin
        if (mem_re) begin
          issued_q <= issued_q + 1'b1;
          addr_q   <= addr_q + ADDR_W'(STRIDE);
        end
        if (pop) acc_q <= acc_q + 1'b1;
      end
    end
  end

  // Read data is pushed the edge after it arrives; credits ensure a free slot.
  cnn_weight_reader_fifo #(
    .W     (DW),
    .DEPTH (2),
    .CW    (2)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight_q),
    .push_dat (mem_rdata),
    .pop      (pop),
    .head_dat (fifo_head),
    .count    (fifo_cnt)
  );

  assign mem_addr  = addr_q;
  assign busy      = (state_q == FETCH) || (state_q == DRAIN);
  assign done      = (state_q == FINISH);
  assign start_err = start && (state_q != IDLE);
  assign out_data  = out_valid ? fifo_head : '0;
  assign out_last  = out_valid && (acc_q == num_q - 1'b1);

`ifdef CNN_READER_CHECKSUM_EN
  logic [WORD_W-1:0] window_sum;

  // Modulo sum of all words in the head window.
  always_comb begin
    window_sum = '0;
    for (int i = 0; i < WORDS_PER_READ; i++) begin
      window_sum = window_sum + fifo_head[i*WORD_W +: WORD_W];
    end
  end

  // Running checksum of accepted windows, restarted with each run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         checksum <= '0;
    else if (start_acc) checksum <= '0;
    else if (pop)       checksum <= checksum + window_sum;
  end
`endif
endmodule

// File: tb/tb_cnn_weight_reader.sv
// Directed bench for cnn_weight_reader: reset, basic run, back-pressure, address wrap,
// zero-length run, start while busy / at finish, and reset mid-run.
`timescale 1ns/1ps
module tb_cnn_weight_reader;
  localparam int ADDR_W = 16;
  localparam int WORD_W = 16;
  localparam int WPR    = 25;
  localparam int STRIDE = 25;
  localparam int CNT_W  = 12;
  localparam int DW     = WPR * WORD_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  num_reads = '0;
  logic              busy, done, start_err, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DW-1:0]     mem_rdata = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DW-1:0]     out_data;
  logic              out_last;
`ifdef CNN_READER_CHECKSUM_EN
  logic [WORD_W-1:0] checksum;
`endif

  int checks = 0;
  int errors = 0;

  cnn_weight_reader #(
    .ADDR_W(ADDR_W), .WORD_W(WORD_W), .WORDS_PER_READ(WPR), .STRIDE(STRIDE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_reads(num_reads),
    .busy(busy), .done(done), .start_err(start_err), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last)
`ifdef CNN_READER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // Memory contents: word at address a holds a*7 + 0x0311 (mod 2^16).
  function automatic logic [WORD_W-1:0] mword(input logic [ADDR_W-1:0] a);
    logic [WORD_W-1:0] r;
    r = a * 16'd7 + 16'h0311;
    return r;
  endfunction

  function automatic logic [DW-1:0] mwin(input logic [ADDR_W-1:0] a);
    logic [DW-1:0] w;
    logic [ADDR_W-1:0] x;
    w = '0;
    for (int j = 0; j < WPR; j++) begin
      x = a + ADDR_W'(j);
      w[j*WORD_W +: WORD_W] = mword(x);
    end
    return w;
  endfunction

  // Monitor records (sampled mid-cycle on the falling edge).
  int                cyc_n = 0;
  logic [ADDR_W-1:0] addr_q[$];
  int                addr_cyc[$];
  logic [DW-1:0]     win_q[$];
  logic              last_q[$];
  int                acc_cyc[$];
  int                done_n = 0, done_cyc = -1, err_n = 0, err_cyc = -1, valid_n = 0, hold_viol = 0;
  logic              prev_stall = 1'b0;
  logic [DW-1:0]     prev_dat = '0;
  logic              prev_last = 1'b0;
  logic              rd_pend = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DW-1:0]     junk;
  assign junk = {WPR{16'hBEEF}};

  always @(negedge clk) begin
    if (mem_re) begin addr_q.push_back(mem_addr); addr_cyc.push_back(cyc_n); end
    if (out_valid) valid_n++;
    if (out_valid && out_ready) begin
      win_q.push_back(out_data); last_q.push_back(out_last); acc_cyc.push_back(cyc_n);
    end
    if (done) begin done_n++; done_cyc = cyc_n; end
    if (start_err) begin err_n++; err_cyc = cyc_n; end
    if (prev_stall && (!out_valid || out_data !== prev_dat || out_last !== prev_last)) hold_viol++;
    prev_stall = out_valid && !out_ready;
    prev_dat   = out_data;
    prev_last  = out_last;
    rd_pend    = mem_re;
    rd_addr    = mem_addr;
  end

  // Cycle counter and memory responder (data valid the cycle after mem_re).
  always @(posedge clk) begin
    cyc_n++;
    mem_rdata <= rd_pend ? mwin(rd_addr) : junk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n, output int s);
    step();
    start = 1'b1; base_addr = b; num_reads = n; s = cyc_n;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = done;
    end
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (start_err !== 1'b0) begin errors++; $display("FAIL reset_start_err got %b want 0", start_err); end
    checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL reset_mem_re got %b want 0", mem_re); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data nonzero want 0"); end
`ifdef CNN_READER_CHECKSUM_EN
    checks++; if (checksum !== '0) begin errors++; $display("FAIL reset_checksum got %h want 0", checksum); end
`endif
    step();
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_basic();
    int s, a0, w0, d0;
    bit ok;
    a0 = addr_q.size(); w0 = win_q.size(); d0 = done_n;
    out_ready = 1'b1;
    pulse_start(16'd0, 12'd3, s);
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done timeout, want done within 100 cycles"); end
    checks++; if (addr_q.size() - a0 != 3) begin errors++; $display("FAIL basic_nreads got %0d want 3", addr_q.size() - a0); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (a0 + k >= addr_q.size() || addr_q[a0+k] !== 16'(k * 25) || addr_cyc[a0+k] != s + 1 + k) begin
        errors++; $display("FAIL basic_addr%0d got %h@%0d want %h@%0d", k, addr_q[a0+k], addr_cyc[a0+k], 16'(k * 25), s + 1 + k);
      end
      checks++;
      if (w0 + k >= win_q.size() || win_q[w0+k] !== mwin(16'(k * 25)) || last_q[w0+k] !== (k == 2)) begin
        errors++; $display("FAIL basic_win%0d data/last mismatch, last got %b want %b", k, last_q[w0+k], (k == 2));
      end
    end
    checks++; if (acc_cyc[w0] != s + 3) begin errors++; $display("FAIL basic_first_valid got cycle %0d want %0d", acc_cyc[w0], s + 3); end
    checks++; if (done_n - d0 != 1 || done_cyc != acc_cyc[w0+2] + 1) begin
      errors++; $display("FAIL basic_done_pulse got %0d pulses @%0d want 1 @%0d", done_n - d0, done_cyc, acc_cyc[w0+2] + 1);
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", busy); end
    step();
  endtask

  task automatic test_back_pressure();
    int s, a0, w0, d0, h0, re_before;
    bit ok;
    a0 = addr_q.size(); w0 = win_q.size(); d0 = done_n; h0 = hold_viol;
    out_ready = 1'b0;
    pulse_start(16'd200, 12'd4, s);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = out_valid; end
    checks++; if (!ok) begin errors++; $display("FAIL bp_first_valid timeout, want out_valid within 20 cycles"); end
    repeat (10) step();
    re_before = addr_q.size() - a0;
    out_ready = 1'b1;
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_done timeout, want done within 100 cycles"); end
    checks++; if (re_before != 2) begin errors++; $display("FAIL bp_reads_in_stall got %0d want 2", re_before); end
    checks++; if (hold_viol != h0) begin errors++; $display("FAIL bp_hold got %0d violations want 0", hold_viol - h0); end
    checks++; if (win_q.size() - w0 != 4) begin errors++; $display("FAIL bp_nwin got %0d want 4", win_q.size() - w0); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (w0 + k >= win_q.size() || win_q[w0+k] !== mwin(16'(200 + k * 25)) || last_q[w0+k] !== (k == 3)) begin
        errors++; $display("FAIL bp_win%0d data/last mismatch, last got %b want %b", k, last_q[w0+k], (k == 3));
      end
    end
    checks++; if (done_n - d0 != 1) begin errors++; $display("FAIL bp_done_count got %0d want 1", done_n - d0); end
  endtask

  task automatic test_wrap();
    int s, a0, w0;
    bit ok;
    a0 = addr_q.size(); w0 = win_q.size();
    out_ready = 1'b1;
    pulse_start(16'hFFF0, 12'd2, s);
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_done timeout"); end
    checks++; if (addr_q[a0] !== 16'hFFF0 || addr_q[a0+1] !== 16'h0009 || addr_q.size() - a0 != 2) begin
      errors++; $display("FAIL wrap_addr got %h,%h want fff0,0009", addr_q[a0], addr_q[a0+1]);
    end
    checks++; if (win_q[w0] !== mwin(16'hFFF0) || win_q[w0+1] !== mwin(16'h0009)) begin
      errors++; $display("FAIL wrap_data window contents got wrong values");
    end
  endtask

  task automatic test_zero_count();
    int s, a0, v0, d0;
    bit ok;
    a0 = addr_q.size(); v0 = valid_n; d0 = done_n;
    pulse_start(16'h1234, 12'd0, s);
    wait_done(20, ok);
    repeat (3) step();
    checks++; if (!ok || done_cyc != s + 2 || done_n - d0 != 1) begin
      errors++; $display("FAIL zero_done got %0d pulses @%0d want 1 @%0d", done_n - d0, done_cyc, s + 2);
    end
    checks++; if (addr_q.size() != a0) begin errors++; $display("FAIL zero_mem_re got %0d reads want 0", addr_q.size() - a0); end
    checks++; if (valid_n != v0) begin errors++; $display("FAIL zero_out_valid got %0d want 0", valid_n - v0); end
  endtask

  task automatic test_start_while_busy();
    int s, a0, w0, d0, e0;
    bit ok;
    a0 = addr_q.size(); w0 = win_q.size(); d0 = done_n; e0 = err_n;
    out_ready = 1'b1;
    pulse_start(16'd50, 12'd3, s);
    start = 1'b1; base_addr = 16'd999; num_reads = 12'd7;
    step();
    start = 1'b0;
    wait_done(100, ok);
    repeat (3) step();
    checks++; if (err_n - e0 != 1 || err_cyc != s + 1) begin
      errors++; $display("FAIL busy_start_err got %0d pulses @%0d want 1 @%0d", err_n - e0, err_cyc, s + 1);
    end
    checks++; if (addr_q.size() - a0 != 3 || addr_q[a0] !== 16'd50 || addr_q[a0+1] !== 16'd75 || addr_q[a0+2] !== 16'd100) begin
      errors++; $display("FAIL busy_addrs got %0d reads, want 50,75,100", addr_q.size() - a0);
    end
    checks++; if (win_q.size() - w0 != 3 || win_q[w0+2] !== mwin(16'd100)) begin
      errors++; $display("FAIL busy_windows got %0d want 3 intact", win_q.size() - w0);
    end
    checks++; if (done_n - d0 != 1) begin errors++; $display("FAIL busy_done got %0d want 1", done_n - d0); end
  endtask

  task automatic test_start_at_finish();
    int s, a0, d0, e0;
    a0 = addr_q.size(); d0 = done_n; e0 = err_n;
    out_ready = 1'b1;
    pulse_start(16'd7, 12'd1, s);
    repeat (3) step();
    start = 1'b1; base_addr = 16'd500; num_reads = 12'd2;
    step();
    start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL finish_busy got %b want 0", busy); end
    repeat (4) step();
    checks++; if (done_n - d0 != 1 || done_cyc != s + 4) begin
      errors++; $display("FAIL finish_done got %0d @%0d want 1 @%0d", done_n - d0, done_cyc, s + 4);
    end
    checks++; if (err_n - e0 != 1 || err_cyc != s + 4) begin
      errors++; $display("FAIL finish_start_err got %0d @%0d want 1 @%0d", err_n - e0, err_cyc, s + 4);
    end
    checks++; if (addr_q.size() - a0 != 1) begin errors++; $display("FAIL finish_reads got %0d want 1", addr_q.size() - a0); end
  endtask

  task automatic test_reset_mid_run();
    int s, d0, w0;
    bit ok;
    logic [WORD_W-1:0] exp_sum;
    d0 = done_n;
    out_ready = 1'b1;
    pulse_start(16'd300, 12'd3, s);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || mem_re !== 1'b0 || mem_addr !== '0) begin
      errors++; $display("FAIL midrst_ctrl got busy=%b done=%b re=%b addr=%h want all 0", busy, done, mem_re, mem_addr);
    end
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || start_err !== 1'b0) begin
      errors++; $display("FAIL midrst_out got valid=%b last=%b want all 0", out_valid, out_last);
    end
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();
    checks++; if (done_n != d0) begin errors++; $display("FAIL midrst_no_done got %0d pulses want 0", done_n - d0); end
    w0 = win_q.size();
    pulse_start(16'd100, 12'd1, s);
    wait_done(100, ok);
    checks++; if (!ok || addr_q[addr_q.size()-1] !== 16'd100) begin
      errors++; $display("FAIL midrst_rerun_addr got %h want 0064", addr_q[addr_q.size()-1]);
    end
    checks++; if (win_q.size() - w0 != 1 || win_q[w0] !== mwin(16'd100) || last_q[w0] !== 1'b1) begin
      errors++; $display("FAIL midrst_rerun_win got %0d windows want 1 correct", win_q.size() - w0);
    end
    exp_sum = '0;
    for (int j = 0; j < WPR; j++) exp_sum = exp_sum + mword(16'(100 + j));
`ifdef CNN_READER_CHECKSUM_EN
    checks++; if (checksum !== exp_sum) begin errors++; $display("FAIL midrst_checksum got %h want %h", checksum, exp_sum); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_wrap();
    test_zero_count();
    test_start_while_busy();
    test_start_at_finish();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
